alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a request/response handshake: single-cycle logic/arith/compare
// ops, and bit-serial shifts that take one cycle per bit of shift amount.
module alu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  br_flag,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [SHAMT_W-1:0]    cnt;
  logic [DATA_WIDTH-1:0] acc;
  logic [3:0]            op_q;
  logic [SHAMT_W-1:0]    shamt_in;

  assign shamt_in = src_b[SHAMT_W-1:0];

  function automatic logic is_shift(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
  endfunction

  // Returns {br_flag, alu_result}; shift codes return A unshifted (the shamt 0 case).
  function automatic logic [DATA_WIDTH:0] alu_eval(input logic [3:0] op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] res;
    logic lt;
    logic flag;
    a_s  = a;
    b_s  = b;
    diff = a - b;
    lt   = (a_s < b_s);
    res  = '0;
    flag = 1'b0;
    case (op)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0010: res = a + b;
      4'b0110: res = a ^ b;
      4'b0100, 4'b0101, 4'b0111: res = a;
      4'b1100: res = {{(DATA_WIDTH-1){1'b0}}, lt};
      4'b1000: begin res = diff; flag = (a == b); end
      4'b1001: begin res = diff; flag = (a != b); end
      4'b1010: begin res = diff; flag = lt; end
      4'b1011: begin res = diff; flag = ~lt; end
      default: begin res = '0; flag = 1'b0; end
    endcase
    return {flag, res};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] v);
    case (op)
      4'b0100: return {v[DATA_WIDTH-2:0], 1'b0};
      4'b0101: return {1'b0, v[DATA_WIDTH-1:1]};
      4'b0111: return {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid)
          state_nxt = (is_shift(operation) && (shamt_in != '0)) ? SHIFT : DONE;
      end
      SHIFT: if (cnt == CNT_ONE) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate in SHIFT, hold everything in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc        <= '0;
      cnt        <= '0;
      op_q       <= '0;
      alu_result <= '0;
      br_flag    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= operation;
            if (is_shift(operation) && (shamt_in != '0)) begin
              acc     <= src_a;
              cnt     <= shamt_in;
              br_flag <= 1'b0;
            end else begin
              {br_flag, alu_result} <= alu_eval(operation, src_a, src_b);
            end
          end
        end
        SHIFT: begin
          acc <= shift_step(op_q, acc);
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) alu_result <= shift_step(op_q, acc);
        end
        default: ;
      endcase
    end
  end

endmodule
